// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: sequential/relative/absolute/hold-back
// updates, call/return through a circular return-address stack, and single-level interrupts.
module pc_unit #(
  parameter int                PC_W       = 32,
  parameter int                OFF_W      = 16,
  parameter bit                SIGNED_OFF = 1'b0,
  parameter logic [PC_W-1:0]   RESET_VEC  = PC_W'(32),
  parameter logic [PC_W-1:0]   INT_VEC    = PC_W'(0),
  parameter int                RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        pc_src,
  input  logic [OFF_W-1:0]  offset,
  input  logic [PC_W-1:0]   target,
  input  logic              int_req,
  input  logic              int_ret,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   epc,
  output logic              in_isr,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] SRC_INC    = 3'b000;
  localparam logic [2:0] SRC_REL    = 3'b001;
  localparam logic [2:0] SRC_DEC    = 3'b010;
  localparam logic [2:0] SRC_ABS    = 3'b011;
  localparam logic [2:0] SRC_CALL   = 3'b100;
  localparam logic [2:0] SRC_RETURN = 3'b101;

  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [PC_W-1:0]  epc_reg, epc_next;
  logic             in_isr_reg, in_isr_next;
  logic [PTR_W-1:0] ras_ptr_reg, ras_ptr_next;
  logic [CNT_W-1:0] ras_cnt_reg, ras_cnt_next;
  logic             ras_err_reg, ras_err_next;
  logic             ras_push;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  ras_top;

  // ras_ptr_reg is the next slot to write; when full it wraps onto the oldest entry.
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

  generate
    if (OFF_W == PC_W) begin : g_off_full
      assign off_ext = offset;
    end else if (SIGNED_OFF) begin : g_off_sext
      assign off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    end else begin : g_off_zext
      assign off_ext = {{(PC_W-OFF_W){1'b0}}, offset};
    end
  endgenerate

  assign pc_inc  = pc_reg + PC_W'(1);
  assign ras_top = ras_mem[ras_ptr_reg - PTR_W'(1)];

  always_comb begin
    pc_next      = pc_reg;
    epc_next     = epc_reg;
    in_isr_next  = in_isr_reg;
    ras_ptr_next = ras_ptr_reg;
    ras_cnt_next = ras_cnt_reg;
    ras_err_next = ras_err_reg;
    ras_push     = 1'b0;

    if (int_req && !in_isr_reg) begin
      epc_next    = pc_reg;
      pc_next     = INT_VEC;
      in_isr_next = 1'b1;
    end else if (stall) begin
      pc_next = pc_reg;
    end else if (int_ret && in_isr_reg) begin
      pc_next     = epc_reg;
      in_isr_next = 1'b0;
    end else begin
      case (pc_src)
        SRC_REL: pc_next = pc_reg + off_ext;
        SRC_DEC: pc_next = pc_reg - PC_W'(1);
        SRC_ABS: pc_next = target;
        SRC_CALL: begin
          ras_push     = 1'b1;
          pc_next      = target;
          ras_ptr_next = ras_ptr_reg + PTR_W'(1);
          if (ras_cnt_reg == CNT_W'(RAS_DEPTH)) begin
            ras_err_next = 1'b1;
          end else begin
            ras_cnt_next = ras_cnt_reg + CNT_W'(1);
          end
        end
        SRC_RETURN: begin
          if (ras_cnt_reg != '0) begin
            pc_next      = ras_top;
            ras_ptr_next = ras_ptr_reg - PTR_W'(1);
            ras_cnt_next = ras_cnt_reg - CNT_W'(1);
          end else begin
            pc_next      = pc_inc;
            ras_err_next = 1'b1;
          end
        end
        default: pc_next = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= RESET_VEC;
      epc_reg     <= '0;
      in_isr_reg  <= 1'b0;
      ras_ptr_reg <= '0;
      ras_cnt_reg <= '0;
      ras_err_reg <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      epc_reg     <= epc_next;
      in_isr_reg  <= in_isr_next;
      ras_ptr_reg <= ras_ptr_next;
      ras_cnt_reg <= ras_cnt_next;
      ras_err_reg <= ras_err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && ras_push) begin
      ras_mem[ras_ptr_reg] <= pc_inc;
    end
  end

  assign pc        = pc_reg;
  assign epc       = epc_reg;
  assign in_isr    = in_isr_reg;
  assign ras_empty = (ras_cnt_reg == '0);
  assign ras_full  = (ras_cnt_reg == CNT_W'(RAS_DEPTH));
  assign ras_err   = ras_err_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one unsigned-offset and one signed-offset instance share
// the stimulus; a vector table walks the main sequence, followed by a held-interrupt sequence.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, int_req, int_ret;
  logic [2:0]  pc_src;
  logic [15:0] offset;
  logic [31:0] target;
  logic [31:0] pc_u, epc_u, pc_s, epc_s;
  logic        in_isr_u, empty_u, full_u, err_u;
  logic        in_isr_s, empty_s, full_s, err_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_unit #(.SIGNED_OFF(1'b0)) dut_u (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .offset(offset),
    .target(target), .int_req(int_req), .int_ret(int_ret), .pc(pc_u), .epc(epc_u),
    .in_isr(in_isr_u), .ras_empty(empty_u), .ras_full(full_u), .ras_err(err_u)
  );

  pc_unit #(.SIGNED_OFF(1'b1)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .offset(offset),
    .target(target), .int_req(int_req), .int_ret(int_ret), .pc(pc_s), .epc(epc_s),
    .in_isr(in_isr_s), .ras_empty(empty_s), .ras_full(full_s), .ras_err(err_s)
  );

  typedef struct {
    logic        rst, stl;
    logic [2:0]  src;
    logic [15:0] off;
    logic [31:0] tgt;
    logic        ireq, iret;
    logic [31:0] exp_pc, exp_pc_s, exp_epc;
    logic        exp_isr, exp_empty, exp_full, exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic stl, input logic [2:0] src,
                     input logic [15:0] off, input logic [31:0] tgt,
                     input logic ireq, input logic iret,
                     input logic [31:0] e_pc, input logic [31:0] e_pc_s,
                     input logic [31:0] e_epc, input logic e_isr,
                     input logic e_empty, input logic e_full, input logic e_err);
    vec_t v;
    v.rst = rst; v.stl = stl; v.src = src; v.off = off; v.tgt = tgt;
    v.ireq = ireq; v.iret = iret;
    v.exp_pc = e_pc; v.exp_pc_s = e_pc_s; v.exp_epc = e_epc;
    v.exp_isr = e_isr; v.exp_empty = e_empty; v.exp_full = e_full; v.exp_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s step%0d: got %h expected %h", tag, idx, got, want);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic [2:0] src,
                       input logic [15:0] off, input logic [31:0] tgt,
                       input logic ireq, input logic iret);
    reset = rst; stall = stl; pc_src = src; offset = off; target = tgt;
    int_req = ireq; int_ret = iret;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [31:0] e_pc, input logic [31:0] e_pc_s,
                           input logic [31:0] e_epc, input logic e_isr, input logic e_empty,
                           input logic e_full, input logic e_err);
    check("pc_u", idx, pc_u, e_pc);
    check("pc_s", idx, pc_s, e_pc_s);
    check("epc", idx, epc_u, e_epc);
    check("in_isr", idx, {31'b0, in_isr_u}, {31'b0, e_isr});
    check("ras_empty", idx, {31'b0, empty_u}, {31'b0, e_empty});
    check("ras_full", idx, {31'b0, full_u}, {31'b0, e_full});
    check("ras_err", idx, {31'b0, err_u}, {31'b0, e_err});
    $display("step%0d pc=%h pc_s=%h epc=%h isr=%b empty=%b full=%b err=%b",
             idx, pc_u, pc_s, epc_u, in_isr_u, empty_u, full_u, err_u);
  endtask

  initial begin
    // rst stl src off tgt ireq iret | pc pc_s epc isr empty full err
    add(1, 0, 3'd0, 16'h0, 32'd0,   0, 0, 32'd32, 32'd32, 32'd0, 0, 1, 0, 0);
    add(1, 0, 3'd0, 16'h0, 32'd0,   0, 0, 32'd32, 32'd32, 32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd0, 16'h0, 32'd0,   0, 0, 32'd33, 32'd33, 32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd0, 16'h0, 32'd0,   0, 0, 32'd34, 32'd34, 32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd0, 16'h0, 32'd0,   0, 0, 32'd35, 32'd35, 32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd3, 16'h0, 32'd40,  0, 0, 32'd40, 32'd40, 32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd1, 16'hFFFE, 32'd0, 0, 0, 32'h0001_0026, 32'd38, 32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd3, 16'h0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd0, 16'h0, 32'd0,   0, 0, 32'd0,  32'd0,  32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd2, 16'h0, 32'd0,   0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd7, 16'h0, 32'd0,   0, 0, 32'd0,  32'd0,  32'd0, 0, 1, 0, 0);
    add(0, 0, 3'd3, 16'h0, 32'd50,  0, 0, 32'd50, 32'd50, 32'd0, 0, 1, 0, 0);
    // nested call/return
    add(0, 0, 3'd4, 16'h0, 32'd100, 0, 0, 32'd100, 32'd100, 32'd0, 0, 0, 0, 0);
    add(0, 0, 3'd4, 16'h0, 32'd200, 0, 0, 32'd200, 32'd200, 32'd0, 0, 0, 0, 0);
    add(0, 0, 3'd5, 16'h0, 32'd0,   0, 0, 32'd101, 32'd101, 32'd0, 0, 0, 0, 0);
    add(0, 0, 3'd5, 16'h0, 32'd0,   0, 0, 32'd51,  32'd51,  32'd0, 0, 1, 0, 0);
    // overflow: fifth call overwrites the oldest entry (52)
    add(0, 0, 3'd4, 16'h0, 32'd300, 0, 0, 32'd300, 32'd300, 32'd0, 0, 0, 0, 0);
    add(0, 0, 3'd4, 16'h0, 32'd400, 0, 0, 32'd400, 32'd400, 32'd0, 0, 0, 0, 0);
    add(0, 0, 3'd4, 16'h0, 32'd500, 0, 0, 32'd500, 32'd500, 32'd0, 0, 0, 0, 0);
    add(0, 0, 3'd4, 16'h0, 32'd600, 0, 0, 32'd600, 32'd600, 32'd0, 0, 0, 1, 0);
    add(0, 0, 3'd4, 16'h0, 32'd700, 0, 0, 32'd700, 32'd700, 32'd0, 0, 0, 1, 1);
    add(0, 0, 3'd5, 16'h0, 32'd0,   0, 0, 32'd601, 32'd601, 32'd0, 0, 0, 0, 1);
    add(0, 0, 3'd5, 16'h0, 32'd0,   0, 0, 32'd501, 32'd501, 32'd0, 0, 0, 0, 1);
    add(0, 0, 3'd5, 16'h0, 32'd0,   0, 0, 32'd401, 32'd401, 32'd0, 0, 0, 0, 1);
    add(0, 0, 3'd5, 16'h0, 32'd0,   0, 0, 32'd301, 32'd301, 32'd0, 0, 1, 0, 1);
    add(0, 0, 3'd5, 16'h0, 32'd0,   0, 0, 32'd302, 32'd302, 32'd0, 0, 1, 0, 1);
    // interrupt entry overrides stall; nested request ignored; RTI
    add(0, 0, 3'd3, 16'h0, 32'd60,  0, 0, 32'd60, 32'd60, 32'd0,  0, 1, 0, 1);
    add(0, 1, 3'd0, 16'h0, 32'd0,   1, 0, 32'd0,  32'd0,  32'd60, 1, 1, 0, 1);
    add(0, 0, 3'd0, 16'h0, 32'd0,   0, 0, 32'd1,  32'd1,  32'd60, 1, 1, 0, 1);
    add(0, 0, 3'd0, 16'h0, 32'd0,   1, 0, 32'd2,  32'd2,  32'd60, 1, 1, 0, 1);
    add(0, 0, 3'd3, 16'h0, 32'd999, 0, 1, 32'd60, 32'd60, 32'd60, 0, 1, 0, 1);
    add(0, 0, 3'd0, 16'h0, 32'd0,   0, 1, 32'd61, 32'd61, 32'd60, 0, 1, 0, 1);
    // stall holds pc and RAS
    add(0, 1, 3'd3, 16'h0, 32'd500, 0, 0, 32'd61, 32'd61, 32'd60, 0, 1, 0, 1);
    add(0, 1, 3'd3, 16'h0, 32'd500, 0, 0, 32'd61, 32'd61, 32'd60, 0, 1, 0, 1);
    add(0, 1, 3'd3, 16'h0, 32'd500, 0, 0, 32'd61, 32'd61, 32'd60, 0, 1, 0, 1);
    add(0, 1, 3'd4, 16'h0, 32'd80,  0, 0, 32'd61, 32'd61, 32'd60, 0, 1, 0, 1);
    // reset during ISR with a non-empty RAS
    add(0, 0, 3'd4, 16'h0, 32'd80,  0, 0, 32'd80, 32'd80, 32'd60, 0, 0, 0, 1);
    add(0, 0, 3'd0, 16'h0, 32'd0,   1, 0, 32'd0,  32'd0,  32'd80, 1, 0, 0, 1);
    add(0, 1, 3'd0, 16'h0, 32'd0,   0, 1, 32'd0,  32'd0,  32'd80, 1, 0, 0, 1);
    add(1, 0, 3'd0, 16'h0, 32'd0,   0, 0, 32'd32, 32'd32, 32'd0,  0, 1, 0, 0);
    add(0, 0, 3'd5, 16'h0, 32'd0,   0, 0, 32'd33, 32'd33, 32'd0,  0, 1, 0, 1);
    add(1, 0, 3'd0, 16'h0, 32'd0,   0, 0, 32'd32, 32'd32, 32'd0,  0, 1, 0, 0);

    reset = 1'b1; stall = 1'b0; pc_src = 3'd0; offset = '0; target = '0;
    int_req = 1'b0; int_ret = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].src, vecs[i].off, vecs[i].tgt,
            vecs[i].ireq, vecs[i].iret);
      check_all(i, vecs[i].exp_pc, vecs[i].exp_pc_s, vecs[i].exp_epc, vecs[i].exp_isr,
                vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_err);
    end

    // int_req held high across RTI re-enters the handler on the following cycle
    drive(0, 0, 3'd3, 16'h0, 32'd70, 0, 0);
    check_all(100, 32'd70, 32'd70, 32'd0, 0, 1, 0, 0);
    drive(0, 0, 3'd0, 16'h0, 32'd0, 1, 0);
    check_all(101, 32'd0, 32'd0, 32'd70, 1, 1, 0, 0);
    drive(0, 0, 3'd0, 16'h0, 32'd0, 1, 0);
    check_all(102, 32'd1, 32'd1, 32'd70, 1, 1, 0, 0);
    drive(0, 0, 3'd0, 16'h0, 32'd0, 1, 1);
    check_all(103, 32'd70, 32'd70, 32'd70, 0, 1, 0, 0);
    drive(0, 0, 3'd0, 16'h0, 32'd0, 1, 0);
    check_all(104, 32'd0, 32'd0, 32'd70, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit, the successor to the fixed 32-bit PC, sitting at the head of the fetch stage. It supports sequential, relative, absolute and hold-back (pc-1) updates, plus call/return through a small return-address stack (RAS). It takes interrupts with hardware save/restore of the return PC through an EPC register. Pipeline stall and RTI are first-class inputs.

Parameters:
- PC_W, 32, PC and target width.
- OFF_W, 16, branch offset width (must be ≤ PC_W).
- SIGNED_OFF, 0: offset is zero-extended. 1: offset is sign-extended.
- RESET_VEC, 32, PC value loaded on reset.
- INT_VEC, 0, PC value loaded on interrupt entry.
- RAS_DEPTH, 4, number of return-address stack entries (power of 2, ≥ 2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  holds PC and RAS for this cycle.
- pc_src  in  3  update select:
  - 000 pc+1
  - 001 pc+ext(offset)
  - 010 pc-1
  - 011 target
  - 100 call
  - 101 return
  - 110/111 treated as 000
- offset  in  OFF_W  relative branch offset.
- target  in  PC_W  absolute jump/call target.
- int_req  in  1  interrupt request (level; sampled each cycle).
- int_ret  in  1  return from interrupt (RTI).
- pc  out  PC_W  current program counter.
- epc  out  PC_W  saved interrupt return PC.
- in_isr  out  1  interrupt handler active.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  sticky: RAS overflow or underflow has occurred.

Behaviour:
- Registered outputs; every update takes effect at the next posedge, so latency is 1 cycle.
- Reset values: pc=RESET_VEC (loaded directly, no pre-decrement), epc=0, in_isr=0, RAS count=0, ras_empty=1, ras_full=0, ras_err=0.
- Reset mid-operation discards any pending call, return or ISR state.
- Per-cycle priority, highest first:
  1. reset.
  2. int_req && !in_isr: epc<=pc; pc<=INT_VEC; in_isr<=1. This overrides stall, pc_src and int_ret; the instruction at the old pc re-executes after RTI.
  3. stall: pc, epc, in_isr and RAS all hold.
  4. int_ret && in_isr: pc<=epc; in_isr<=0. pc_src is ignored.
  5. pc_src decode.
- int_req while in_isr is ignored and not latched; the requester keeps it asserted if still pending. Nested interrupts are not supported.
- int_ret while !in_isr: ignored; pc_src decodes normally.
- Arithmetic: all pc results are modulo 2^PC_W.
  - ext(offset) is zero- or sign-extended to PC_W according to SIGNED_OFF.
  - Wrap-around is silent (pc=all-ones, +1 gives 0; pc=0, -1 gives all-ones).
- Call (100): push pc+1, then pc<=target.
  - If the RAS is full, the oldest entry is overwritten (circular buffer), count stays RAS_DEPTH, and ras_err<=1.
- Return (101): if non-empty, pc<=top entry, pop, count-1.
  - If empty, pc<=pc+1 and ras_err<=1.
- ras_err clears only on reset.
- RAS contents are unaffected by interrupt entry and RTI.

Test Plan:
1. reset=1 for 2 cycles, then pc_src=000 for 3 cycles -> pc=32 after reset, then 33, 34, 35.
2. pc=40, pc_src=001, offset=16'hFFFE: SIGNED_OFF=0 -> pc=0x0001_0026; SIGNED_OFF=1 -> pc=38. Also pc=0xFFFF_FFFF, pc_src=000 -> pc=0.
3. pc=50, call target=100, then at 100 call target=200, then return, return -> pc: 100, 200, 101, 51; ras_empty=1, ras_err=0.
4. Push 5 calls with RAS_DEPTH=4 -> ras_full=1, ras_err=1. Then 5 returns: the first 4 return to the most recent 4 return addresses; the 5th gives pc+1 with ras_err still 1.
5. pc=60, stall=1 with int_req=1 -> pc=0, epc=60, in_isr=1. A second int_req during the ISR is ignored. int_ret=1 -> pc=60, in_isr=0.
6. stall=1 with pc_src=011, target=500 for 3 cycles -> pc unchanged. Then reset asserted during the ISR with the RAS non-empty -> pc=32, in_isr=0, ras_empty=1, ras_err=0.
